// File: rtl/bpu_resolve_update.sv
// Branch resolution: flags mispredicts, issues a registered redirect/flush and queues BTB updates.
// Latency: redirect/flush one cycle after EX; a queued write is visible one cycle after enqueue.
// Backpressure: head held while !btb_wr_ready; a push into a full queue is dropped unless a pop frees a slot that cycle.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module bpu_resolve_update #(
    parameter int DRAIN_CYCLES = 2,
    parameter int WQ_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_type,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_hit,
    input  logic [31:0] ex_pred_npc,
    input  logic [1:0]  ex_pred_cnt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        btb_wr_valid,
    input  logic        btb_wr_ready,
    output logic [31:0] btb_wr_pc,
    output logic [2:0]  btb_wr_type,
    output logic [31:0] btb_wr_target,
    output logic [1:0]  btb_wr_cnt,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
    output logic [31:0] stat_drops
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int AW = $clog2(WQ_DEPTH);
    localparam logic [DW-1:0] DRAIN_C = DW'(DRAIN_CYCLES);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(WQ_DEPTH);
    localparam logic [2:0]    T_BCON  = 3'b001;

    typedef enum logic [0:0] {
        S_IDLE,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] target;
        logic [1:0]  cnt;
    } wr_ent_t;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          redir_vld_q, redir_vld_d;
    logic [31:0]   redir_pc_q, redir_pc_d;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    wr_ent_t       mem_q [WQ_DEPTH];

    logic          is_branch;
    logic          accepted;
    logic [31:0]   actual_npc;
    logic          mispredict;
    logic [1:0]    new_cnt;
    logic          wr_gen;
    logic          wq_vld;
    logic          full;
    logic          pop;
    logic          push;
    wr_ent_t       new_ent;
    wr_ent_t       head;

    assign is_branch  = (ex_type != 3'b000) && (ex_type != 3'b111);
    assign accepted   = ex_valid && is_branch && (state_q == S_IDLE);
    assign actual_npc = ex_taken ? ex_target : (ex_pc + 32'd4);
    assign mispredict = accepted && (ex_pred_npc != actual_npc);

    // Only conditional branches train the counter; every other type is pinned strongly taken.
    always_comb begin
        new_cnt = 2'b11;
        if (ex_type == T_BCON) begin
            if (ex_pred_hit) begin
                if (ex_taken) begin
                    new_cnt = (ex_pred_cnt == 2'b11) ? 2'b11 : ex_pred_cnt + 2'b01;
                end else begin
                    new_cnt = (ex_pred_cnt == 2'b00) ? 2'b00 : ex_pred_cnt - 2'b01;
                end
            end else begin
                new_cnt = ex_taken ? 2'b10 : 2'b01;
            end
        end
    end

    assign wr_gen = accepted &&
                    ((!ex_pred_hit && ex_taken) ||
                     (ex_pred_hit && ((new_cnt != ex_pred_cnt) || mispredict)));

    assign new_ent = '{pc: ex_pc, typ: ex_type, target: ex_target, cnt: new_cnt};

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d     = S_FLUSH;
                    drain_d     = DRAIN_C;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = actual_npc;
                end
            end
            S_FLUSH: begin
                if (drain_q <= DW'(1)) begin
                    state_d = S_IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                drain_d = '0;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign wq_vld = (count_q != '0);
    assign full   = (count_q == DEPTH_C);
    assign pop    = wq_vld && btb_wr_ready;
    assign push   = wr_gen && (!full || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_ent;
            end
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;
    assign flush          = (state_q == S_FLUSH);
    assign btb_wr_valid   = wq_vld;
    assign btb_wr_pc      = head.pc;
    assign btb_wr_type    = head.typ;
    assign btb_wr_target  = head.target;
    assign btb_wr_cnt     = head.cnt;

`ifdef BPU_STATS_EN
    logic        drop;
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_drop_q;

    assign drop = wr_gen && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q   <= '0;
            stat_mis_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            if (accepted) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
            if (drop) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
    assign stat_drops       = stat_drop_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
    assign stat_drops       = '0;
`endif

endmodule

// File: tb/tb_bpu_resolve_update.sv
// Bench for bpu_resolve_update: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based reference model.
module tb_bpu_resolve_update;
    localparam int DRAIN = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_type;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_hit;
    logic [31:0] ex_pred_npc;
    logic [1:0]  ex_pred_cnt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        btb_wr_valid;
    logic        btb_wr_ready;
    logic [31:0] btb_wr_pc;
    logic [2:0]  btb_wr_type;
    logic [31:0] btb_wr_target;
    logic [1:0]  btb_wr_cnt;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic [31:0] stat_drops;

    bpu_resolve_update #(.DRAIN_CYCLES(DRAIN), .WQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_hit(ex_pred_hit), .ex_pred_npc(ex_pred_npc),
        .ex_pred_cnt(ex_pred_cnt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .btb_wr_valid(btb_wr_valid), .btb_wr_ready(btb_wr_ready),
        .btb_wr_pc(btb_wr_pc), .btb_wr_type(btb_wr_type), .btb_wr_target(btb_wr_target),
        .btb_wr_cnt(btb_wr_cnt),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts), .stat_drops(stat_drops)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, flush as cycles remaining.
    typedef struct {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] tgt;
        logic [1:0]  cnt;
    } wr_t;

    wr_t         mq[$];
    bit          m_rv;
    logic [31:0] m_rpc;
    int          m_flush;
    int unsigned m_br, m_mis, m_drop;

    function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef BPU_STATS_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    function automatic logic [1:0] upd_cnt(input logic [2:0] t, input logic hit,
                                           input logic taken, input logic [1:0] c);
        int v;
        if (t != 3'd1) return 2'd3;
        if (!hit) return taken ? 2'd2 : 2'd1;
        v = int'(c) + (taken ? 1 : -1);
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    task automatic model_step();
        bit          acc, mis;
        logic [31:0] actual;
        logic [1:0]  c;
        if (rst) begin
            mq.delete();
            m_rv = 0; m_rpc = '0; m_flush = 0;
            m_br = 0; m_mis = 0; m_drop = 0;
            return;
        end
        if (mq.size() > 0 && btb_wr_ready) void'(mq.pop_front());
        acc = ex_valid && ex_type >= 3'd1 && ex_type <= 3'd6 && m_flush == 0;
        m_rv = 0;
        if (m_flush > 0) m_flush--;
        if (acc) begin
            actual = ex_taken ? ex_target : ex_pc + 32'd4;
            mis = (ex_pred_npc != actual);
            c = upd_cnt(ex_type, ex_pred_hit, ex_taken, ex_pred_cnt);
            m_br++;
            if (mis) m_mis++;
            if ((!ex_pred_hit && ex_taken) || (ex_pred_hit && (c != ex_pred_cnt || mis))) begin
                if (mq.size() < DEPTH) mq.push_back('{ex_pc, ex_type, ex_target, c});
                else m_drop++;
            end
            if (mis) begin
                m_rv = 1; m_rpc = actual; m_flush = DRAIN;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush", flush, m_flush > 0);
        chk("btb_wr_valid", btb_wr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("btb_wr_pc", btb_wr_pc, mq[0].pc);
            chk("btb_wr_type", btb_wr_type, mq[0].typ);
            chk("btb_wr_target", btb_wr_target, mq[0].tgt);
            chk("btb_wr_cnt", btb_wr_cnt, mq[0].cnt);
        end
        chk("stat_branches", stat_branches, exp_stat(m_br));
        chk("stat_mispredicts", stat_mispredicts, exp_stat(m_mis));
        chk("stat_drops", stat_drops, exp_stat(m_drop));
    end

    task automatic send(input logic [31:0] pc, input logic [2:0] t, input logic tk,
                        input logic [31:0] tgt, input logic hit, input logic [31:0] npc,
                        input logic [1:0] c);
        ex_valid = 1'b1; ex_pc = pc; ex_type = t; ex_taken = tk;
        ex_target = tgt; ex_pred_hit = hit; ex_pred_npc = npc; ex_pred_cnt = c;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] act;
        rst = 1'b1; btb_wr_ready = 1'b1;
        ex_valid = 0; ex_pc = '0; ex_type = '0; ex_taken = 0; ex_target = '0;
        ex_pred_hit = 0; ex_pred_npc = '0; ex_pred_cnt = '0;
        repeat (2) step();
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_wr_valid", btb_wr_valid, 0);
        chk("rst_wr_pc", btb_wr_pc, 0);
        chk("rst_stat_br", stat_branches, 0);
        rst = 1'b0;

        // Conditional branch mispredicted as not-taken.
        send(32'h100, 3'd1, 1, 32'h200, 1, 32'h104, 2'd1);
        step(); idle();
        chk("t1_redirect_valid", redirect_valid, 1);
        chk("t1_redirect_pc", redirect_pc, 32'h200);
        chk("t1_flush", flush, 1);
        chk("t1_wr_pc", btb_wr_pc, 32'h100);
        chk("t1_wr_type", btb_wr_type, 3'd1);
        chk("t1_wr_target", btb_wr_target, 32'h200);
        chk("t1_wr_cnt", btb_wr_cnt, 2'd2);
        step();
        chk("t1_flush_c2", flush, 1);
        chk("t1_redirect_pulse", redirect_valid, 0);
        step();
        chk("t1_flush_end", flush, 0);

        // JAL miss, then a not-taken conditional miss predicted correctly.
        send(32'h300, 3'd2, 1, 32'h400, 0, 32'h304, 2'd0);
        step(); idle();
        chk("t2_redirect_pc", redirect_pc, 32'h400);
        chk("t2_wr_cnt", btb_wr_cnt, 2'd3);
        step(); step();
        send(32'h500, 3'd1, 0, 32'h600, 0, 32'h504, 2'd0);
        step(); idle();
        chk("t2_nt_redirect", redirect_valid, 0);
        chk("t2_nt_wr_valid", btb_wr_valid, 0);

        // Back-to-back mispredicts: only the first acts.
        send(32'h700, 3'd1, 1, 32'h800, 1, 32'h704, 2'd2);
        step();
        chk("t3_first_redirect", redirect_pc, 32'h800);
        send(32'h710, 3'd1, 1, 32'h810, 1, 32'h714, 2'd2);
        step();
        chk("t3_second_ignored", redirect_valid, 0);
        send(32'h720, 3'd1, 1, 32'h820, 1, 32'h724, 2'd2);
        step(); idle();
        chk("t3_third_ignored", redirect_valid, 0);
        chk("t3_flush_end", flush, 0);
        chk("t3_stat_br", stat_branches, exp_stat(4));
        chk("t3_stat_mis", stat_mispredicts, exp_stat(3));

        // Saturated counter, correct prediction: nothing happens.
        send(32'hB80, 3'd1, 1, 32'hB00, 1, 32'hB00, 2'd3);
        step(); idle();
        chk("t5_redirect", redirect_valid, 0);
        chk("t5_wr_valid", btb_wr_valid, 0);

        // Stalled write port: third push dropped, head held.
        btb_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h900 + 32'(i * 16), 3'd1, 1, 32'hA00 + 32'(i * 16), 0,
                 32'hA00 + 32'(i * 16), 2'd0);
            step();
            chk("t4_head_held", btb_wr_pc, 32'h900);
        end
        chk("t4_stat_drops", stat_drops, exp_stat(1));
        send(32'h930, 3'd1, 1, 32'hA30, 0, 32'hA30, 2'd0);
        btb_wr_ready = 1'b1;
        step(); idle();
        chk("t4_pop_push_head", btb_wr_pc, 32'h910);
        chk("t4_no_new_drop", stat_drops, exp_stat(1));
        step();
        chk("t4_last_entry", btb_wr_pc, 32'h930);
        step();
        chk("t4_drained", btb_wr_valid, 0);

        // Reset during flush with queued writes.
        btb_wr_ready = 1'b0;
        send(32'hC00, 3'd1, 1, 32'hD00, 0, 32'hD00, 2'd0);
        step();
        send(32'hC10, 3'd1, 1, 32'hD10, 0, 32'hD10, 2'd0);
        step();
        send(32'hC20, 3'd1, 1, 32'hD20, 0, 32'hC24, 2'd0);
        step(); idle();
        chk("t6_flush_before", flush, 1);
        chk("t6_wr_before", btb_wr_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; btb_wr_ready = 1'b1;
        chk("t6_flush_cleared", flush, 0);
        chk("t6_wr_cleared", btb_wr_valid, 0);
        chk("t6_stats_cleared", stat_branches, 0);
        chk("t6_drops_cleared", stat_drops, 0);

        // Randomized traffic with phases of heavy backpressure.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit stall_phase;
            stall_phase = ((cyc / 200) % 2) == 1;
            rst = ($urandom_range(0, 299) == 0);
            btb_wr_ready = stall_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_type = 3'($urandom_range(0, 7));
            ex_pc = 32'($urandom_range(0, 255)) << 2;
            ex_target = 32'($urandom_range(0, 255)) << 2;
            ex_taken = (ex_type == 3'd1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
            ex_pred_hit = 1'($urandom_range(0, 1));
            ex_pred_cnt = 2'($urandom_range(0, 3));
            act = ex_taken ? ex_target : ex_pc + 32'd4;
            ex_pred_npc = ($urandom_range(0, 2) != 0) ? act : (32'($urandom_range(0, 255)) << 2);
            step();
        end
        rst = 1'b0; idle(); btb_wr_ready = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
